ps2_transmitter: RTL and testbench



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 58 +++++
 rtl/ps2_transmitter.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command bytes
// and the microsecond-to-cycle helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FIN
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // 64-bit intermediate: 120 us * 50 MHz overflows 32 bits
    function automatic int us_to_cycles(input int us, input int clk_hz);
        longint c;
        c = longint'(us) * longint'(clk_hz) / longint'(1_000_000);
        return int'(c);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_LEN debounce
// and single-cycle fall/rise pulses. Idle (reset) level is high.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall,
    output logic rise
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[0], line_in};
        filt_d = filt_q;
        cnt_d  = '0;
        // count consecutive samples that disagree with the accepted level
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
        rise_d = ~filt_q & filt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
            rise_q <= rise_d;
        end
    end

    assign level = filt_q;
    assign fall  = fall_q;
    assign rise  = rise_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter (open-drain enables on PS2Clk/PS2Data).
// Define PS2_TX_ACK_CHECK_EN to turn a NACK into err and add nack_seen.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
`ifdef PS2_TX_ACK_CHECK_EN
    output logic       err,
    output logic       nack_seen
`else
    output logic       err
`endif
);

    localparam int INH_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
    localparam int TO_CYC  = us_to_cycles(TIMEOUT_US, CLK_HZ);
    localparam int TMR_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fail_q, fail_d;
    logic [1:0]    kdat_sync_q, kdat_sync_d;
    logic          kdat;
    logic          kclk_lvl, kclk_fall, kclk_rise;
    logic          timed;
`ifdef PS2_TX_ACK_CHECK_EN
    logic          nack_q, nack_d;
`endif

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_kclk_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_in(kclk_in),
        .level  (kclk_lvl),
        .fall   (kclk_fall),
        .rise   (kclk_rise)
    );

    assign kdat_sync_d = {kdat_sync_q[0], kdata_in};
    assign kdat        = kdat_sync_q[1];

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + TW'(1);
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        kdata_oe_d = kdata_oe_q;
        fail_d     = fail_q;
`ifdef PS2_TX_ACK_CHECK_EN
        nack_d     = nack_q;
`endif
        timed = state_q inside {ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE};

        unique case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (tx_start) begin
                    shift_d   = {1'b1, ~^tx_byte, tx_byte};
                    bit_cnt_d = '0;
                    fail_d    = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
                    nack_d    = 1'b0;
`endif
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (tmr_q == INH_LAST) begin
                    kdata_oe_d = 1'b1;
                    tmr_d      = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                tmr_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (kclk_fall) begin
                    kdata_oe_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    tmr_d      = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (kclk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (kdat) begin
                        fail_d = 1'b1;
                        nack_d = 1'b1;
                    end
`endif
                    tmr_d   = '0;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // device releasing the clock starts the data-release wait
                if (kclk_rise) begin
                    tmr_d = '0;
                end
                if (kclk_lvl && kdat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (timed && tmr_q == TO_LAST) begin
            kdata_oe_d = 1'b0;
            fail_d     = 1'b1;
            tmr_d      = '0;
            state_d    = ST_FIN;
        end

        kclk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_FIN));
        done_d    = (state_d == ST_FIN) && !fail_d;
        err_d     = (state_d == ST_FIN) && fail_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            kclk_oe_q   <= 1'b0;
            kdata_oe_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fail_q      <= 1'b0;
            kdat_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            kclk_oe_q   <= kclk_oe_d;
            kdata_oe_q  <= kdata_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            kdat_sync_q <= kdat_sync_d;
        end
    end

`ifdef PS2_TX_ACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nack_q <= 1'b0;
        end else begin
            nack_q <= nack_d;
        end
    end

    assign nack_seen = nack_q;
`endif

    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Scoreboard bench for ps2_transmitter with a 12.5 kHz PS/2 device model,
// timeout, NACK, async reset and clock-glitch scenarios.
module tb_ps2_transmitter;

    localparam int CLK_HZ     = 5_000_000;
    localparam int INHIBIT_US = 120;
    localparam int TIMEOUT_US = 200;
    localparam int FILTER_LEN = 8;
    localparam int INH_EXP    = 600;
    localparam int HALF       = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_start = 1'b0;
    logic       kclk_in, kdata_in;
    logic       kclk_oe, kdata_oe, busy, done, err;
`ifdef PS2_TX_ACK_CHECK_EN
    logic       nack_seen;
`endif

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch = 1'b0;
    bit   glitch_en = 1'b0;
    int   dev_mode = 0;
    bit   dev_busy = 1'b0;
    int   dev_bit = 0;

    int tests = 0;
    int fails = 0;

    logic [10:0] frame_q[$];
    bit          chk_q[$];
    bit          res_q[$];
    logic [10:0] dev_got, dev_exp;
    bit          dev_chk;
    bit          exp_res;

    assign kclk_in  = ~(kclk_oe | dev_clk_low | glitch);
    assign kdata_in = ~(kdata_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_transmitter #(
        .CLK_HZ    (CLK_HZ),
        .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_US(TIMEOUT_US),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .kclk_in  (kclk_in),
        .kdata_in (kdata_in),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .busy     (busy),
        .done     (done),
`ifdef PS2_TX_ACK_CHECK_EN
        .err      (err),
        .nack_seen(nack_seen)
`else
        .err      (err)
`endif
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_byte  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while ((busy || dev_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL wait_end: still busy after %0d cycles", budget);
        end
    endtask

    // device model: samples start bit at request, then one bit per rise
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && kdata_oe && !kclk_oe && dev_mode != 2) begin
                dev_busy   = 1'b1;
                dev_got    = '0;
                dev_got[0] = kdata_in;
                dev_bit    = 1;
                for (int i = 1; i <= 10; i++) begin
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    dev_got[i] = kdata_in;
                    dev_bit = i + 1;
                end
                repeat (HALF / 2) @(negedge clk);
                dev_data_low = (dev_mode == 0);
                repeat (HALF / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2) @(negedge clk);
                dev_data_low = 1'b0;
                if (frame_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame: unexpected frame %b", dev_got);
                end else begin
                    dev_exp = frame_q.pop_front();
                    dev_chk = chk_q.pop_front();
                    if (dev_chk) begin
                        check("frame", 32'(dev_got), 32'(dev_exp));
                    end
                end
                dev_busy = 1'b0;
                dev_bit  = 0;
            end
        end
    end

    // result monitor
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            check("done_err_excl", 32'(done & err), 0);
            check("busy_at_end", 32'(busy), 0);
            if (res_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL result: unexpected done=%0b err=%0b", done, err);
            end else begin
                exp_res = res_q.pop_front();
                check("result_err", 32'(err), 32'(exp_res));
            end
        end
    end

    // inhibit length monitor
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (kclk_oe && !kdata_oe) begin
                run++;
            end else if (run != 0) begin
                check("inhibit_len", 32'(run), INH_EXP);
                run = 0;
            end
        end
    end

    initial begin
        forever begin
            repeat (137) @(negedge clk);
            if (glitch_en) begin
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_kclk_oe", 32'(kclk_oe), 0);
        check("rst_kdata_oe", 32'(kdata_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0xED: parity 1
        dev_mode = 0;
        frame_q.push_back(11'b11_1110_1101_0);
        chk_q.push_back(1'b1);
        res_q.push_back(1'b0);
        start_tx(8'hED);
        wait_end(20000);

        // 0x07: parity 0; tx_start during the done cycle is ignored
        frame_q.push_back(11'b10_0000_0111_0);
        chk_q.push_back(1'b1);
        res_q.push_back(1'b0);
        start_tx(8'h07);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_07", 32'(done), 1);
        tx_byte  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start_on_done_ignored", 32'(busy), 0);
        wait_end(2000);

        // silent device: timeout
        dev_mode = 2;
        res_q.push_back(1'b1);
        start_tx(8'hF4);
        n = 0;
        while (!err && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", 32'(err), 1);
        @(negedge clk);
        check("timeout_lines", 32'({kclk_oe, kdata_oe}), 0);
        check("timeout_busy", 32'(busy), 0);
        dev_mode = 0;

        // NACK from device
        dev_mode = 1;
        frame_q.push_back(11'b10_1111_0100_0);
        chk_q.push_back(1'b1);
`ifdef PS2_TX_ACK_CHECK_EN
        res_q.push_back(1'b1);
`else
        res_q.push_back(1'b0);
`endif
        start_tx(8'hF4);
        wait_end(20000);
`ifdef PS2_TX_ACK_CHECK_EN
        check("nack_seen_set", 32'(nack_seen), 1);
`endif
        dev_mode = 0;

        // async reset in the middle of 0xF4 (d3 = 0 on the wire)
        frame_q.push_back(11'b10_1111_0100_0);
        chk_q.push_back(1'b0);
        start_tx(8'hF4);
`ifdef PS2_TX_ACK_CHECK_EN
        check("nack_seen_cleared", 32'(nack_seen), 0);
`endif
        n = 0;
        while (dev_bit != 5 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_kdata_oe", 32'(kdata_oe), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({kclk_oe, kdata_oe, busy, done, err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_end(20000);

        // 0xFF after reset
        frame_q.push_back(11'b11_1111_1111_0);
        chk_q.push_back(1'b1);
        res_q.push_back(1'b0);
        start_tx(8'hFF);
        wait_end(20000);

        // 0x55 with kclk glitches and a tx_start while busy
        glitch_en = 1'b1;
        frame_q.push_back(11'b11_0101_0101_0);
        chk_q.push_back(1'b1);
        res_q.push_back(1'b0);
        start_tx(8'h55);
        repeat (1500) @(negedge clk);
        tx_byte  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_poke", 32'(busy), 1);
        wait_end(20000);
        glitch_en = 1'b0;
        repeat (20) @(negedge clk);

        check("leftover_expect", 32'(frame_q.size() + res_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
